dmem_responder: RTL and testbench

- Data-memory responder for the 16-bit multi-cycle RISC core.
- Sits on the far side of the core's load/store interface and answers word read/write requests with a ready/valid handshake and a configurable number of wait states.
- The core's controller holds its request in its load (WB_MEM) and STORE states until this block signals completion.
- Storage is word-addressed and 16 bits wide.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_array.sv | 75 +++++++
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_responder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - state_t      : FSM state encoding (IDLE=0, WAIT=1, READ_RSP=2, WRITE_CMT=3)
//   - DMEM_DATA_W  : default data word width
//   - even_parity  : parity helper, only used when DMEM_PARITY_EN is defined
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam int DMEM_DATA_W = 16;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT      = 2'd1,
      S_READ_RSP  = 2'd2,
      S_WRITE_CMT = 2'd3
   } state_t;

   // Even parity: the returned bit makes the total number of ones even.
   function automatic logic even_parity(input logic [DMEM_DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word storage for dmem_responder: 2**ADDR_W words of DATA_W bits, synchronous
// write and registered read. With DMEM_PARITY_EN defined each word carries one
// extra even-parity bit generated from the write data.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   async active-low reset (clears the read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write word address
//   wr_data  in   write data
//   rd_en    in   read strobe; read register updates only when set
//   rd_addr  in   read word address
//   rd_data  out  registered read data (holds between reads)
//   rd_par   out  registered stored parity bit (DMEM_PARITY_EN only)
// -----------------------------------------------------------------------------
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
`ifdef DMEM_PARITY_EN
   ,
   output logic              rd_par
`endif
);

`ifdef DMEM_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif

   logic [WORD_W-1:0] mem_reg [2**ADDR_W];
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word_reg;

`ifdef DMEM_PARITY_EN
   assign wr_word = {even_parity(wr_data), wr_data};
`else
   assign wr_word = wr_data;
`endif

   // Storage itself has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_addr] <= wr_word;
      end
   end

   // Read register is enabled so the last read word stays on rd_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_word_reg <= '0;
      end else if (rd_en) begin
         rd_word_reg <= mem_reg[rd_addr];
      end
   end

   assign rd_data = rd_word_reg[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
   assign rd_par  = rd_word_reg[DATA_W];
`endif

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the 16-bit multi-cycle core. Accepts one word
// read/write request at a time (req & ready), inserts WAIT_CYC wait states,
// then either returns read data with a one-cycle rvalid pulse or commits the
// write with a one-cycle wr_done pulse.
//
// Optional feature: define DMEM_PARITY_EN to add per-word even parity and the
// perr output (asserted with rvalid when the stored word fails its check).
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   async active-low reset
//   req      in   request valid
//   we       in   1 = write, 0 = read (sampled with req)
//   addr     in   word address (sampled with req)
//   wdata    in   write data (sampled with req)
//   ready    out  request can be accepted this cycle
//   rvalid   out  read data valid, one-cycle pulse
//   rdata    out  read data, meaningful while rvalid=1
//   wr_done  out  write committed, one-cycle pulse
//   busy     out  transaction in flight (= !ready)
//   perr     out  parity error with rvalid (DMEM_PARITY_EN only)
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = DMEM_DATA_W,
   parameter int WAIT_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              wr_done,
   output logic              busy
`ifdef DMEM_PARITY_EN
   ,
   output logic              perr
`endif
);

   localparam bit       ZERO_WAIT = (WAIT_CYC == 0);
   localparam bit [3:0] CNT_LOAD  = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   state_t              state_reg;
   logic [3:0]          cnt_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic                we_reg;
   logic [DATA_W-1:0]   wdata_reg;
   logic                ready_reg;
   logic                rvalid_reg;
   logic                wr_done_reg;

   logic                accept;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic                wr_en;
   logic [DATA_W-1:0]   rd_data;
`ifdef DMEM_PARITY_EN
   logic                rd_par;
`endif

   assign accept = req & ready_reg;

   // The array read is registered, so it is launched on the edge that moves
   // the FSM into READ_RSP. With no wait states that is the accept edge
   // itself, so the address comes straight from the port in IDLE.
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = addr_reg;
      if (state_reg == S_IDLE) begin
         rd_addr = addr;
         if (accept && ZERO_WAIT && !we) begin
            rd_en = 1'b1;
         end
      end else if (state_reg == S_WAIT && cnt_reg == 4'd0 && !we_reg) begin
         rd_en = 1'b1;
      end
   end

   // Write lands on the edge that ends WRITE_CMT, before ready re-asserts,
   // so a following read of the same address sees the new data.
   assign wr_en = (state_reg == S_WRITE_CMT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= 4'd0;
         addr_reg    <= '0;
         we_reg      <= 1'b0;
         wdata_reg   <= '0;
         ready_reg   <= 1'b1;
         rvalid_reg  <= 1'b0;
         wr_done_reg <= 1'b0;
      end else begin
         rvalid_reg  <= 1'b0;
         wr_done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  addr_reg  <= addr;
                  we_reg    <= we;
                  wdata_reg <= wdata;
                  ready_reg <= 1'b0;
                  if (!ZERO_WAIT) begin
                     state_reg <= S_WAIT;
                     cnt_reg   <= CNT_LOAD;
                  end else if (we) begin
                     state_reg   <= S_WRITE_CMT;
                     wr_done_reg <= 1'b1;
                  end else begin
                     state_reg  <= S_READ_RSP;
                     rvalid_reg <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_reg == 4'd0) begin
                  if (we_reg) begin
                     state_reg   <= S_WRITE_CMT;
                     wr_done_reg <= 1'b1;
                  end else begin
                     state_reg  <= S_READ_RSP;
                     rvalid_reg <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            S_READ_RSP, S_WRITE_CMT: begin
               state_reg <= S_IDLE;
               ready_reg <= 1'b1;
            end
            default: begin
               state_reg <= S_IDLE;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

   dmem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (addr_reg),
      .wr_data (wdata_reg),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
`ifdef DMEM_PARITY_EN
      ,
      .rd_par  (rd_par)
`endif
   );

   assign ready   = ready_reg;
   assign busy    = ~ready_reg;
   assign rvalid  = rvalid_reg;
   assign wr_done = wr_done_reg;
   assign rdata   = rd_data;

`ifdef DMEM_PARITY_EN
   // Recompute parity over the stored data and compare with the stored bit.
   assign perr = rvalid_reg & (even_parity(rd_data) ^ rd_par);
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Three instances share clk/rst_n:
//   index 0 : WAIT_CYC=0, index 1 : WAIT_CYC=1, index 2 : WAIT_CYC=3.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_a     [3];
   logic        we_a      [3];
   logic [7:0]  addr_a    [3];
   logic [15:0] wdata_a   [3];
   logic        ready_a   [3];
   logic        rvalid_a  [3];
   logic        wr_done_a [3];
   logic        busy_a    [3];
   logic [15:0] rdata_a   [3];
`ifdef DMEM_PARITY_EN
   logic        perr_a    [3];
`endif

   int checks = 0;
   int errors = 0;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         localparam int WC = (gi == 2) ? 3 : gi;
         dmem_responder #(
            .ADDR_W   (8),
            .DATA_W   (16),
            .WAIT_CYC (WC)
         ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (req_a[gi]),
            .we      (we_a[gi]),
            .addr    (addr_a[gi]),
            .wdata   (wdata_a[gi]),
            .ready   (ready_a[gi]),
            .rvalid  (rvalid_a[gi]),
            .rdata   (rdata_a[gi]),
            .wr_done (wr_done_a[gi]),
            .busy    (busy_a[gi])
`ifdef DMEM_PARITY_EN
            ,
            .perr    (perr_a[gi])
`endif
         );
      end
   endgenerate

   // rvalid and wr_done must never be high together on any instance.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int i = 0; i < 3; i++) begin
            if (rvalid_a[i] === 1'b1 || wr_done_a[i] === 1'b1) begin
               checks++;
               if (rvalid_a[i] === 1'b1 && wr_done_a[i] === 1'b1) begin
                  errors++;
                  $display("FAIL pulse_overlap idx=%0d: rvalid=%b wr_done=%b, required not both 1",
                           i, rvalid_a[i], wr_done_a[i]);
               end
            end
         end
      end
   end

   // Hard stop so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Waits (bounded) for ready, presents one request, and returns at the
   // falling edge just after the accept edge with req dropped.
   task automatic issue(input int idx, input logic w, input logic [7:0] a, input logic [15:0] d);
      int n;
      n = 0;
      while (ready_a[idx] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (ready_a[idx] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL issue_ready idx=%0d: ready=%b, required 1", idx, ready_a[idx]);
      end
      req_a[idx]   = 1'b1;
      we_a[idx]    = w;
      addr_a[idx]  = a;
      wdata_a[idx] = d;
      @(negedge clk);
      req_a[idx]   = 1'b0;
   endtask

   // Counts falling edges from the first one after the accept edge (0) until
   // rvalid or wr_done; lat=-1 on timeout. Returns at the response edge.
   task automatic wait_resp(input int idx, output int lat, output logic [15:0] data, output bit rd);
      lat  = -1;
      data = '0;
      rd   = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (rvalid_a[idx] === 1'b1) begin
            lat  = i;
            data = rdata_a[idx];
            rd   = 1'b1;
            break;
         end
         if (wr_done_a[idx] === 1'b1) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks += 5;
         if (ready_a[i] !== 1'b1) begin errors++; $display("FAIL reset_ready idx=%0d: got %b, required 1", i, ready_a[i]); end
         if (busy_a[i] !== 1'b0) begin errors++; $display("FAIL reset_busy idx=%0d: got %b, required 0", i, busy_a[i]); end
         if (rvalid_a[i] !== 1'b0) begin errors++; $display("FAIL reset_rvalid idx=%0d: got %b, required 0", i, rvalid_a[i]); end
         if (wr_done_a[i] !== 1'b0) begin errors++; $display("FAIL reset_wr_done idx=%0d: got %b, required 0", i, wr_done_a[i]); end
         if (rdata_a[i] !== 16'h0000) begin errors++; $display("FAIL reset_rdata idx=%0d: got %h, required 0000", i, rdata_a[i]); end
      end
      $display("reset: all outputs checked on 3 instances");
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      int lat; logic [15:0] d; bit rd;
      issue(1, 1'b1, 8'h05, 16'hBEEF);
      checks += 3;   // cycle 1
      if (ready_a[1] !== 1'b0) begin errors++; $display("FAIL wr1_c1_ready: got %b, required 0", ready_a[1]); end
      if (busy_a[1] !== 1'b1) begin errors++; $display("FAIL wr1_c1_busy: got %b, required 1", busy_a[1]); end
      if (wr_done_a[1] !== 1'b0) begin errors++; $display("FAIL wr1_c1_wr_done: got %b, required 0", wr_done_a[1]); end
      @(negedge clk);   // cycle 2
      checks += 2;
      if (wr_done_a[1] !== 1'b1) begin errors++; $display("FAIL wr1_c2_wr_done: got %b, required 1", wr_done_a[1]); end
      if (ready_a[1] !== 1'b0) begin errors++; $display("FAIL wr1_c2_ready: got %b, required 0", ready_a[1]); end
      @(negedge clk);   // cycle 3
      checks += 2;
      if (ready_a[1] !== 1'b1) begin errors++; $display("FAIL wr1_c3_ready: got %b, required 1", ready_a[1]); end
      if (wr_done_a[1] !== 1'b0) begin errors++; $display("FAIL wr1_c3_wr_done: got %b, required 0", wr_done_a[1]); end
      $display("write  w1 addr=05 data=BEEF");
      issue(1, 1'b0, 8'h05, 16'h0000);
      wait_resp(1, lat, d, rd);
      checks += 2;
      if (!rd || lat != 1) begin errors++; $display("FAIL rd1_latency: got lat=%0d rd=%0d, required lat=1 rd=1", lat, rd); end
      if (d !== 16'hBEEF) begin errors++; $display("FAIL rd1_data: got %h, required BEEF", d); end
      @(negedge clk);
      checks++;
      if (rvalid_a[1] !== 1'b0) begin errors++; $display("FAIL rd1_pulse: rvalid=%b one cycle later, required 0", rvalid_a[1]); end
      $display("read   w1 addr=05 data=%h lat=%0d", d, lat);
   endtask

   task automatic test_zero_wait();
      issue(0, 1'b1, 8'h00, 16'h1234);
      checks += 2;
      if (wr_done_a[0] !== 1'b1) begin errors++; $display("FAIL w0_wr_done: got %b, required 1", wr_done_a[0]); end
      if (ready_a[0] !== 1'b0) begin errors++; $display("FAIL w0_wr_ready: got %b, required 0", ready_a[0]); end
      @(negedge clk);
      checks++;
      if (ready_a[0] !== 1'b1) begin errors++; $display("FAIL w0_wr_ready_back: got %b, required 1", ready_a[0]); end
      $display("write  w0 addr=00 data=1234");
      issue(0, 1'b0, 8'h00, 16'h0000);
      checks += 2;
      if (rvalid_a[0] !== 1'b1) begin errors++; $display("FAIL w0_rvalid: got %b, required 1", rvalid_a[0]); end
      if (rdata_a[0] !== 16'h1234) begin errors++; $display("FAIL w0_rdata: got %h, required 1234", rdata_a[0]); end
      $display("read   w0 addr=00 data=%h", rdata_a[0]);
      @(negedge clk);
      checks += 2;
      if (ready_a[0] !== 1'b1) begin errors++; $display("FAIL w0_rd_ready_back: got %b, required 1", ready_a[0]); end
      if (rvalid_a[0] !== 1'b0) begin errors++; $display("FAIL w0_rvalid_pulse: got %b, required 0", rvalid_a[0]); end
   endtask

   task automatic test_busy_req();
      int lat; logic [15:0] d; bit rd;
      logic [15:0] got [4];
      int nrv, accepts;
      bit drop;
      issue(1, 1'b1, 8'h20, 16'h2020); wait_resp(1, lat, d, rd);
      issue(1, 1'b1, 8'h10, 16'h1010); wait_resp(1, lat, d, rd);
      @(negedge clk);
      nrv = 0; accepts = 0; drop = 1'b0;
      req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 8'h20;
      for (int n = 0; n < 20; n++) begin
         if (rvalid_a[1] === 1'b1 && nrv < 4) begin
            got[nrv] = rdata_a[1];
            nrv++;
         end
         if (drop) req_a[1] = 1'b0;
         else if (req_a[1] && ready_a[1] === 1'b1) begin
            accepts++;
            if (accepts == 2) drop = 1'b1;
         end
         @(negedge clk);
         if (accepts == 1) addr_a[1] = 8'h10;
      end
      req_a[1] = 1'b0;
      checks += 2;
      if (accepts != 2) begin errors++; $display("FAIL busy_accepts: got %0d, required 2", accepts); end
      if (nrv != 2) begin errors++; $display("FAIL busy_rvalid_count: got %0d, required 2", nrv); end
      if (nrv >= 2) begin
         checks += 2;
         if (got[0] !== 16'h2020) begin errors++; $display("FAIL busy_first_data: got %h, required 2020", got[0]); end
         if (got[1] !== 16'h1010) begin errors++; $display("FAIL busy_second_data: got %h, required 1010", got[1]); end
         $display("busy   w1 served %h then %h", got[0], got[1]);
      end
   endtask

   task automatic test_reset_mid_write();
      int lat; logic [15:0] d; bit rd;
      bit seen_wd;
      issue(2, 1'b1, 8'h33, 16'h0000);
      wait_resp(2, lat, d, rd);
      checks++;
      if (rd || lat != 3) begin errors++; $display("FAIL w3_wr_latency: got lat=%0d rd=%0d, required lat=3 rd=0", lat, rd); end
      issue(2, 1'b1, 8'h33, 16'hAAAA);
      checks++;
      if (busy_a[2] !== 1'b1) begin errors++; $display("FAIL w3_busy_in_wait: got %b, required 1", busy_a[2]); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 5;
      if (ready_a[2] !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b, required 1", ready_a[2]); end
      if (busy_a[2] !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy_a[2]); end
      if (rvalid_a[2] !== 1'b0) begin errors++; $display("FAIL midrst_rvalid: got %b, required 0", rvalid_a[2]); end
      if (wr_done_a[2] !== 1'b0) begin errors++; $display("FAIL midrst_wr_done: got %b, required 0", wr_done_a[2]); end
      if (rdata_a[2] !== 16'h0000) begin errors++; $display("FAIL midrst_rdata: got %h, required 0000", rdata_a[2]); end
      seen_wd = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (wr_done_a[2] === 1'b1) seen_wd = 1'b1;
      end
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (wr_done_a[2] === 1'b1) seen_wd = 1'b1;
      end
      checks++;
      if (seen_wd) begin errors++; $display("FAIL midrst_no_commit: wr_done seen=1, required 0"); end
      issue(2, 1'b0, 8'h33, 16'h0000);
      wait_resp(2, lat, d, rd);
      checks += 2;
      if (!rd || lat != 3) begin errors++; $display("FAIL midrst_rd_latency: got lat=%0d rd=%0d, required lat=3 rd=1", lat, rd); end
      if (d !== 16'h0000) begin errors++; $display("FAIL midrst_rd_data: got %h, required 0000", d); end
      $display("reset  w3 mid-write addr=33 read back %h", d);
   endtask

   task automatic test_back_to_back();
      int lat; logic [15:0] d; bit rd;
      issue(1, 1'b1, 8'hFF, 16'hFFFF);
      wait_resp(1, lat, d, rd);
      checks++;
      if (rd || lat != 1) begin errors++; $display("FAIL b2b_wr_ff: got lat=%0d rd=%0d, required lat=1 rd=0", lat, rd); end
      issue(1, 1'b1, 8'h00, 16'h0001);
      wait_resp(1, lat, d, rd);
      checks++;
      if (rd || lat != 1) begin errors++; $display("FAIL b2b_wr_00: got lat=%0d rd=%0d, required lat=1 rd=0", lat, rd); end
      issue(1, 1'b0, 8'hFF, 16'h0000);
      wait_resp(1, lat, d, rd);
      checks += 2;
      if (!rd || lat != 1) begin errors++; $display("FAIL b2b_rd_ff_lat: got lat=%0d rd=%0d, required lat=1 rd=1", lat, rd); end
      if (d !== 16'hFFFF) begin errors++; $display("FAIL b2b_rd_ff_data: got %h, required FFFF", d); end
      $display("read   w1 addr=FF data=%h", d);
      issue(1, 1'b0, 8'h00, 16'h0000);
      wait_resp(1, lat, d, rd);
      checks += 2;
      if (!rd || lat != 1) begin errors++; $display("FAIL b2b_rd_00_lat: got lat=%0d rd=%0d, required lat=1 rd=1", lat, rd); end
      if (d !== 16'h0001) begin errors++; $display("FAIL b2b_rd_00_data: got %h, required 0001", d); end
      $display("read   w1 addr=00 data=%h", d);
   endtask

`ifdef DMEM_PARITY_EN
   task automatic test_parity();
      int lat; logic [15:0] d; bit rd;
      issue(1, 1'b1, 8'h40, 16'h00FF); wait_resp(1, lat, d, rd);
      issue(1, 1'b1, 8'h41, 16'h00FF); wait_resp(1, lat, d, rd);
      @(negedge clk);
      g_dut[1].u_dut.u_array.mem_reg[8'h40] = g_dut[1].u_dut.u_array.mem_reg[8'h40] ^ 17'h00008;
      issue(1, 1'b0, 8'h40, 16'h0000);
      wait_resp(1, lat, d, rd);
      checks += 2;
      if (!rd) begin errors++; $display("FAIL par_bad_rvalid: rd=%0d, required 1", rd); end
      if (perr_a[1] !== 1'b1) begin errors++; $display("FAIL par_bad_perr: got %b, required 1", perr_a[1]); end
      issue(1, 1'b0, 8'h41, 16'h0000);
      wait_resp(1, lat, d, rd);
      checks += 2;
      if (perr_a[1] !== 1'b0) begin errors++; $display("FAIL par_good_perr: got %b, required 0", perr_a[1]); end
      if (d !== 16'h00FF) begin errors++; $display("FAIL par_good_data: got %h, required 00FF", d); end
      $display("parity w1 flipped word perr checked, clean word data=%h", d);
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_zero_wait();
      test_busy_req();
      test_reset_mid_write();
      test_back_to_back();
`ifdef DMEM_PARITY_EN
      test_parity();
`endif
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
